lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store controller that initiates every access to the 16-bit data memory from the MEM stage of the processor. It turns core load/store requests (byte or halfword, signed or unsigned) into word-wide DataMem address, write-data and write-enable sequences. Because the memory has no byte enables, byte stores are done as read-modify-write. It returns load data and a completion pulse to the core and stalls the pipeline while an access is in flight.

## Interface
Parameters:
- MEM_LAT, 1: cycles from MemAddr stable to MemDO valid; legal range 1..15.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Req  in  1  core request valid; sampled only in IDLE.
- ReqWr  in  1  1 = store, 0 = load.
- ReqByte  in  1  1 = byte access, 0 = halfword.
- ReqSigned  in  1  sign-extend byte loads; ignored otherwise.
- ReqAddr  in  16  byte address.
- ReqWData  in  16  store data; byte stores use bits [7:0].
- Busy  out  1  stall to core; high from the cycle after acceptance through the RspValid cycle.
- RspValid  out  1  one-cycle completion pulse.
- RspData  out  16  load result, valid with RspValid; 0 for stores.
- AlignErr  out  1  misaligned halfword flag, valid with RspValid.
- MemAddr  out  16  word index {1'b0, ReqAddr[15:1]}.
- MemDI  out  16  write data to memory.
- MemWE  out  1  memory write enable, single cycle.
- MemDO  in  16  read data from memory.

## Operation
- States: IDLE, RD (read wait), WR (write), RESP.
- IDLE, Req=1: latch the request fields. Next state:
  - halfword store → WR
  - load or byte store → RD
  - misaligned halfword (ReqByte=0, ReqAddr[0]=1, only when the Configuration macro is defined) → RESP with the error flag set
- RD: hold MemAddr for MEM_LAT cycles using a down-counter, then capture MemDO. Load → RESP. Byte store → WR.
- WR: MemWE=1 for exactly one cycle, RspValid=1, then return to IDLE.
- RESP: RspValid=1 and RspData driven for one cycle, then IDLE.
- Byte lanes are big-endian: ReqAddr[0]=0 selects bits [15:8]; ReqAddr[0]=1 selects bits [7:0].
- Byte load: the selected byte is zero-extended, or sign-extended when ReqSigned=1.
- Byte store: MemDI is the captured word with only the selected lane replaced by ReqWData[7:0].
- Req while Busy=1 is ignored; the core must not change the request fields then.
- MemAddr, MemDI and MemWE are registered. Outside an access, MemAddr and MemDI hold their last value and MemWE=0.

## Timing
- T0 is the acceptance cycle.
- Halfword store: MemWE and RspValid at T1.
- Load: RspValid at T0+MEM_LAT+1.
- Byte store: MemWE and RspValid at T0+MEM_LAT+1.
- Misaligned halfword: RspValid at T1, with no memory write.
- Back-to-back: a new Req is accepted in the cycle after RspValid.
- Reset: all outputs are 0 and the state is IDLE. Assertion mid-operation aborts immediately: MemWE drops asynchronously and a pending RMW write never occurs.

## Configuration
- LSU_ALIGN_CHK_EN defined: misaligned halfword accesses are trapped. No memory access occurs; the response has AlignErr=1 and RspData=0.
- LSU_ALIGN_CHK_EN undefined: ReqAddr[0] is ignored for halfword accesses, which proceed to the word MemAddr; AlignErr is tied to 0.

## Structure
- Package lsu_pkg holds:
  - state enum (IDLE/RD/WR/RESP)
  - byte-lane select constants
  - MEM_LAT counter width
- Sub-module lsu_lane_merge, purely combinational:
  - byte extract plus sign/zero-extend for loads
  - byte insert for RMW stores
  - instantiated once by lsu_ctrl

## Test plan
All scenarios use MEM_LAT=2.
- Halfword store, ReqAddr 0x0010, data 0xBEEF → at T1: MemWE=1, MemAddr=0x0008, MemDI=0xBEEF, RspValid=1; MemWE=0 at T2.
- Byte load, ReqAddr 0x0011, memory word 0x12F0:
  - signed → RspData=0xFFF0 at T3
  - unsigned → RspData=0x00F0
- Byte store, ReqAddr 0x0010, data 0x00AA, memory word 0x1234 → MemWE=1 with MemDI=0xAA34 at T3; Busy high T1–T3.
- Halfword load, ReqAddr 0x0003:
  - with the macro → AlignErr=1, RspValid at T1, MemWE never asserted
  - without the macro → MemAddr=0x0001, RspValid at T3
- Rst_n pulsed low at T2 of a byte store → MemWE never rises, all outputs 0; the next Req is accepted normally.
- Second Req asserted at T1 of a load → ignored; only one RspValid is produced.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store controller:
//   - lsu_state_e : controller FSM states (IDLE / RD / WR / RESP)
//   - LANE_HI/LO  : byte-lane select values (big-endian: address bit 0 = 0
//                   selects bits [15:8], address bit 0 = 1 selects [7:0])
//   - LAT_CNT_W   : width of the memory-latency down-counter (MEM_LAT <= 15)
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  localparam logic LANE_HI = 1'b0;
  localparam logic LANE_LO = 1'b1;

  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/lsu_lane_merge.sv
// -----------------------------------------------------------------------------
// lsu_lane_merge
// Purely combinational byte-lane helper for the load/store controller.
// Ports:
//   word_i   in  16  memory word read back from DataMem
//   lane_i   in  1   byte lane (LANE_HI = bits [15:8], LANE_LO = bits [7:0])
//   signed_i in  1   sign-extend the extracted byte
//   byte_i   in  8   store byte to insert
//   load_o   out 16  extracted byte, zero- or sign-extended
//   store_o  out 16  word with the selected lane replaced by byte_i
// -----------------------------------------------------------------------------
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [15:0] word_i,
  input  logic        lane_i,
  input  logic        signed_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] load_o,
  output logic [15:0] store_o
);

  logic [7:0] sel_byte;

  assign sel_byte = (lane_i == LANE_HI) ? word_i[15:8] : word_i[7:0];
  assign load_o   = {{8{signed_i & sel_byte[7]}}, sel_byte};
  assign store_o  = (lane_i == LANE_HI) ? {byte_i, word_i[7:0]}
                                        : {word_i[15:8], byte_i};

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store controller for a 16-bit word memory without byte enables.
// Halfword stores are written directly; loads and byte stores first read the
// word (held for MEM_LAT cycles); byte stores then write back the merged word.
// Optional feature: define LSU_ALIGN_CHK_EN to trap misaligned halfword
// accesses (no memory access, AlignErr=1, RspData=0). Without it, address
// bit 0 is ignored for halfwords and AlignErr stays 0.
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Req/ReqWr/ReqByte/ReqSigned/ReqAddr/ReqWData   core request
//   Busy, RspValid, RspData, AlignErr              core response / stall
//   MemAddr, MemDI, MemWE (registered), MemDO       data memory port
// Parameter:
//   MEM_LAT  cycles from MemAddr stable to MemDO valid (1..15)
// -----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        ReqWr,
  input  logic        ReqByte,
  input  logic        ReqSigned,
  input  logic [15:0] ReqAddr,
  input  logic [15:0] ReqWData,
  output logic        Busy,
  output logic        RspValid,
  output logic [15:0] RspData,
  output logic        AlignErr,
  output logic [15:0] MemAddr,
  output logic [15:0] MemDI,
  output logic        MemWE,
  input  logic [15:0] MemDO
);

  // RD lasts MEM_LAT cycles; the counter runs MEM_LAT-1 .. 0 and MemDO is
  // captured on the edge that ends the cycle where it reads 0.
  localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  lsu_state_e           state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 lane_q, lane_d;
  logic                 wr_q, wr_d;
  logic                 byte_q, byte_d;
  logic                 signed_q, signed_d;
  logic [7:0]           wbyte_q, wbyte_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [15:0]          mem_di_q, mem_di_d;
  logic                 mem_we_q, mem_we_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [15:0]          rsp_data_q, rsp_data_d;
  logic                 align_err_q, align_err_d;

  logic                 trap;
  logic [15:0]          load_byte;
  logic [15:0]          store_word;

`ifdef LSU_ALIGN_CHK_EN
  assign trap = ~ReqByte & ReqAddr[0];
`else
  assign trap = 1'b0;
`endif

  lsu_lane_merge u_lane_merge (
    .word_i   (MemDO),
    .lane_i   (lane_q),
    .signed_i (signed_q),
    .byte_i   (wbyte_q),
    .load_o   (load_byte),
    .store_o  (store_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    wr_d        = wr_q;
    byte_d      = byte_q;
    signed_d    = signed_q;
    wbyte_d     = wbyte_q;
    mem_addr_d  = mem_addr_q;
    mem_di_d    = mem_di_q;
    // Pulses and response fields default low so they last exactly one cycle.
    mem_we_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    align_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          lane_d   = ReqAddr[0];
          wr_d     = ReqWr;
          byte_d   = ReqByte;
          signed_d = ReqSigned;
          wbyte_d  = ReqWData[7:0];
          if (trap) begin
            // Trapped access leaves the memory port untouched.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            align_err_d = 1'b1;
          end else begin
            mem_addr_d = {1'b0, ReqAddr[15:1]};
            if (ReqWr && !ReqByte) begin
              state_d     = ST_WR;
              mem_we_d    = 1'b1;
              rsp_valid_d = 1'b1;
              mem_di_d    = ReqWData;
            end else begin
              state_d = ST_RD;
              cnt_d   = CNT_INIT;
            end
          end
        end
      end

      ST_RD: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          if (wr_q) begin
            // Byte store: write back the read word with one lane replaced.
            state_d  = ST_WR;
            mem_we_d = 1'b1;
            mem_di_d = store_word;
          end else begin
            state_d    = ST_RESP;
            rsp_data_d = byte_q ? load_byte : MemDO;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_WR:   state_d = ST_IDLE;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lane_q      <= 1'b0;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      wbyte_q     <= '0;
      mem_addr_q  <= '0;
      mem_di_q    <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      signed_q    <= signed_d;
      wbyte_q     <= wbyte_d;
      mem_addr_q  <= mem_addr_d;
      mem_di_q    <= mem_di_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      align_err_q <= align_err_d;
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign RspValid = rsp_valid_q;
  assign RspData  = rsp_data_q;
  assign AlignErr = align_err_q;
  assign MemAddr  = mem_addr_q;
  assign MemDI    = mem_di_q;
  assign MemWE    = mem_we_q;

endmodule
